chess_sprite_pipe: RTL and testbench

Parametrised, fully pipelined sprite renderer for one chess-piece square on the VGA path. It replaces the per-colour, fixed-size sprite blocks with one block that serves every piece type from a single indexed ROM. It adds transparency, horizontal mirroring, frame-synchronous piece selection and a blinking highlight. It sits between the board/game-state logic and the pixel colour mux, and is instanced once per drawn piece.

---
 rtl/chess_sprite_pkg.sv | 28 ++
 rtl/chess_sprite_pipe_if.sv | 29 ++
 rtl/chess_sprite_rom.sv | 24 ++
 rtl/chess_sprite_pipe.sv | 114 +++++++++++
 tb/tb_chess_sprite_pipe.sv | 136 +++++++++++++
 5 files changed

// File: rtl/chess_sprite_pkg.sv
// Shared types and constants for the chess sprite renderer: piece ids,
// the 12-bit RGB palette and the ROM address-width helper.
package chess_sprite_pkg;

   typedef enum logic [2:0] {
      PAWN   = 3'd0,
      QUEEN  = 3'd1,
      KNIGHT = 3'd2,
      ROOK   = 3'd3,
      BISHOP = 3'd4,
      KING   = 3'd5
   } piece_e;

   localparam int PAL_IDX_W = 4;

   // Entry 0 is never shown: index 0 marks a transparent pixel.
   localparam logic [11:0] PALETTE [2**PAL_IDX_W] = '{
      12'h000, 12'hFFF, 12'h111, 12'h8A3,
      12'hC00, 12'h0C0, 12'h00C, 12'hCC0,
      12'h0CC, 12'hC0C, 12'h888, 12'h444,
      12'hF80, 12'h08F, 12'hA52, 12'h5A2
   };

   function automatic int addr_w(input int types, input int dim);
      return $clog2(types * dim * dim);
   endfunction

endpackage

// File: rtl/chess_sprite_pipe_if.sv
// Pixel-side bundle between the board logic / colour mux and one sprite pipe.
interface chess_sprite_pipe_if;

   logic       frame_start;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
   logic [9:0] offsetX;
   logic [9:0] offsetY;
   logic [2:0] piece_sel;
   logic       highlight;
   logic       flip_x;
   logic [3:0] red;
   logic [3:0] green;
   logic [3:0] blue;
   logic       sprite_on;

   modport master (
      output frame_start, DrawX, DrawY, offsetX, offsetY,
             piece_sel, highlight, flip_x,
      input  red, green, blue, sprite_on
   );

   modport slave (
      input  frame_start, DrawX, DrawY, offsetX, offsetY,
             piece_sel, highlight, flip_x,
      output red, green, blue, sprite_on
   );

endinterface

// File: rtl/chess_sprite_rom.sv
// Synchronous indexed sprite ROM, one palette index per pixel, all piece
// images stacked. Contents are a fixed procedural pattern of the address.
module chess_sprite_rom
   import chess_sprite_pkg::*;
#(
   parameter int DEPTH = 18150,
   parameter int IDX_W = 4,
   parameter int AW    = 15
) (
   input  logic             vga_clk,
   input  logic [AW-1:0]    addr,
   output logic [IDX_W-1:0] idx
);

   function automatic logic [IDX_W-1:0] pattern(input logic [AW-1:0] a);
      logic [AW-1:0] hi;
      hi = a >> IDX_W;
      return a[IDX_W-1:0] ^ hi[IDX_W-1:0];
   endfunction

   always_ff @(posedge vga_clk)
      idx <= (32'(addr) < DEPTH) ? pattern(addr) : '0;

endmodule

// File: rtl/chess_sprite_pipe.sv
// Three-stage sprite renderer for one chess-piece square: box test and
// address, ROM read, palette/transparency/blink. One pixel per clock.
module chess_sprite_pipe
   import chess_sprite_pkg::*;
#(
   parameter int SPRITE_DIM   = 55,
   parameter int PIECE_TYPES  = 6,
   parameter int IDX_W        = 4,
   parameter int BLINK_FRAMES = 16
) (
   input  logic                vga_clk,
   input  logic                reset_n,
   chess_sprite_pipe_if.slave  bus
);

   localparam int AW     = addr_w(PIECE_TYPES, SPRITE_DIM);
   localparam int DEPTH  = PIECE_TYPES * SPRITE_DIM * SPRITE_DIM;
   localparam int FCW    = $clog2(BLINK_FRAMES);
   localparam int STAGES = 1;
   localparam logic [9:0]     DIM     = 10'(SPRITE_DIM);
   localparam logic [FCW-1:0] FC_LAST = FCW'(BLINK_FRAMES - 1);

   logic [2:0]     sel_q;
   logic           hl_q;
   logic           flip_q;
   logic [FCW-1:0] frame_cnt;
   logic           blink_phase;

   // Shadow copies only move on frame_start so a frame never tears.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         sel_q       <= 3'(PAWN);
         hl_q        <= 1'b0;
         flip_q      <= 1'b0;
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (bus.frame_start) begin
         if (32'(bus.piece_sel) < PIECE_TYPES)
            sel_q <= bus.piece_sel;
         hl_q   <= bus.highlight;
         flip_q <= bus.flip_x;
         if (frame_cnt == FC_LAST) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

   logic [9:0]    dx, dy, col;
   logic          in_box;
   logic [AW-1:0] addr_c;

   // Unsigned difference: pixels left of / above the box wrap large and fail.
   always_comb begin
      dx     = bus.DrawX - bus.offsetX;
      dy     = bus.DrawY - bus.offsetY;
      col    = flip_q ? (DIM - 10'd1 - dx) : dx;
      in_box = (dx < DIM) && (dy < DIM);
      addr_c = '0;
      if (in_box)
         addr_c = AW'(32'(sel_q) * SPRITE_DIM * SPRITE_DIM
                      + 32'(dy) * SPRITE_DIM + 32'(col));
   end

   logic [AW-1:0]   addr_q;
   logic [STAGES:0] vld_pipe;
   logic [STAGES:0] inv_pipe;

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q   <= '0;
         vld_pipe <= '0;
         inv_pipe <= '0;
      end else begin
         addr_q   <= addr_c;
         vld_pipe <= {vld_pipe[STAGES-1:0], in_box};
         inv_pipe <= {inv_pipe[STAGES-1:0], hl_q & blink_phase};
      end
   end

   logic [IDX_W-1:0] idx;

   chess_sprite_rom #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W),
      .AW    (AW)
   ) u_rom (
      .vga_clk (vga_clk),
      .addr    (addr_q),
      .idx     (idx)
   );

   logic        opaque;
   logic [11:0] pal, rgb_c;

   always_comb begin
      pal    = PALETTE[PAL_IDX_W'(idx)];
      opaque = vld_pipe[STAGES] && (idx != '0);
      rgb_c  = inv_pipe[STAGES] ? ~pal : pal;
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         {bus.red, bus.green, bus.blue} <= '0;
         bus.sprite_on                  <= 1'b0;
      end else begin
         {bus.red, bus.green, bus.blue} <= opaque ? rgb_c : 12'h000;
         bus.sprite_on                  <= opaque;
      end
   end

endmodule

// File: tb/tb_chess_sprite_pipe.sv
// Directed bench for chess_sprite_pipe: box edges, flip, piece latching,
// transparency, blink phases and mid-line reset, offset at (100,100).
module tb_chess_sprite_pipe;

   logic vga_clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_chk   = 0;
   int   n_pass  = 0;

   chess_sprite_pipe_if bus ();

   chess_sprite_pipe #(
      .SPRITE_DIM   (55),
      .PIECE_TYPES  (6),
      .IDX_W        (4),
      .BLINK_FRAMES (2)
   ) dut (
      .vga_clk (vga_clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 vga_clk = ~vga_clk;

   logic [12:0] o;
   assign o = {bus.sprite_on, bus.red, bus.green, bus.blue};

   task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, got, exp);
   endtask

   // Present a pixel and sample the output it produces three edges later.
   task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y,
                      input logic [12:0] exp);
      @(negedge vga_clk);
      bus.DrawX = x;
      bus.DrawY = y;
      repeat (3) @(posedge vga_clk);
      #1 chk(tag, o, exp);
   endtask

   task automatic fs(input logic [2:0] s, input logic h, input logic f);
      @(negedge vga_clk);
      bus.frame_start = 1'b1;
      bus.piece_sel   = s;
      bus.highlight   = h;
      bus.flip_x      = f;
      @(negedge vga_clk);
      bus.frame_start = 1'b0;
   endtask

   initial begin
      bus.frame_start = 1'b0;
      bus.DrawX       = 10'd0;
      bus.DrawY       = 10'd0;
      bus.offsetX     = 10'd100;
      bus.offsetY     = 10'd100;
      bus.piece_sel   = 3'd0;
      bus.highlight   = 1'b0;
      bus.flip_x      = 1'b0;
      repeat (2) @(posedge vga_clk);
      #1 chk("reset", o, 13'h0000);
      @(negedge vga_clk) reset_n = 1'b1;

      // box edges, pawn, no flip
      pix("x99",    10'd99,  10'd100, 13'h0000);
      pix("x0wrap", 10'd0,   10'd100, 13'h0000);
      pix("x154",   10'd154, 10'd100, 13'h10C0);
      pix("x155",   10'd155, 10'd100, 13'h0000);
      pix("y154",   10'd100, 10'd154, 13'h18A3);
      pix("y155",   10'd100, 10'd155, 13'h0000);
      pix("idx0",   10'd100, 10'd100, 13'h0000);
      pix("dx1",    10'd101, 10'd100, 13'h1FFF);

      // exact latency: out-of-box pixel, then an in-box one
      pix("pre",    10'd99,  10'd100, 13'h0000);
      @(negedge vga_clk);
      bus.DrawX = 10'd154;
      repeat (2) @(posedge vga_clk);
      #1 chk("lat2", o, 13'h0000);
      @(posedge vga_clk);
      #1 chk("lat3", o, 13'h10C0);

      // mirrored row
      fs(3'd0, 1'b0, 1'b1);
      pix("f_dx0",  10'd100, 10'd100, 13'h10C0);
      pix("f_dx1",  10'd101, 10'd100, 13'h100C);
      pix("f_dx53", 10'd153, 10'd100, 13'h1FFF);
      pix("f_dx54", 10'd154, 10'd100, 13'h0000);
      fs(3'd0, 1'b0, 1'b0);
      pix("nf_dx1", 10'd101, 10'd100, 13'h1FFF);

      // mid-frame piece change is ignored until frame_start
      @(negedge vga_clk) bus.piece_sel = 3'd1;
      pix("mid_sel", 10'd101, 10'd100, 13'h1FFF);
      @(negedge vga_clk) bus.frame_start = 1'b1;
      @(negedge vga_clk) bus.frame_start = 1'b0;
      repeat (2) @(posedge vga_clk);
      #1 chk("fs_old", o, 13'h1FFF);
      @(posedge vga_clk);
      #1 chk("fs_new", o, 13'h15A2);
      fs(3'd7, 1'b0, 1'b0);
      pix("sel7",   10'd101, 10'd100, 13'h15A2);
      pix("q_y154", 10'd100, 10'd154, 13'h108F);

      // reset mid-line clears outputs at once; blink restarts in normal phase
      @(negedge vga_clk) reset_n = 1'b0;
      #1 chk("rst_mid", o, 13'h0000);
      repeat (2) @(negedge vga_clk);
      reset_n = 1'b1;
      repeat (2) @(posedge vga_clk);
      #1 chk("rel2", o, 13'h0000);
      @(posedge vga_clk);
      #1 chk("rel3", o, 13'h18A3);

      fs(3'd0, 1'b1, 1'b0);
      pix("blink_f1",   10'd100, 10'd154, 13'h18A3);
      fs(3'd0, 1'b1, 1'b0);
      pix("blink_f2",   10'd100, 10'd154, 13'h175C);
      pix("blink_idx0", 10'd100, 10'd100, 13'h0000);
      fs(3'd0, 1'b1, 1'b0);
      pix("blink_f3",   10'd100, 10'd154, 13'h175C);
      fs(3'd0, 1'b1, 1'b0);
      pix("blink_f4",   10'd100, 10'd154, 13'h18A3);
      fs(3'd0, 1'b1, 1'b0);
      pix("blink_f5",   10'd100, 10'd154, 13'h18A3);
      fs(3'd0, 1'b1, 1'b0);
      pix("blink_f6",   10'd100, 10'd154, 13'h175C);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
